// File: rtl/step_controller_pkg.sv
// -----------------------------------------------------------------------------
// stackCPU_DEFS
//   Shared definitions for the stackCPU single-step / free-run controller.
//   Contents:
//     PC_WIDTH_DEF      width of the stackCPU program counter
//     STEP_COUNT_WIDTH  width of the completed-step counter
//     RATE_WIDTH        width of the run-rate down-counter
//     step_state_t      controller FSM states
//     rate_period()     run-rate period for a given base and rate selector
// -----------------------------------------------------------------------------
package stackCPU_DEFS;

    localparam int unsigned PC_WIDTH_DEF     = 8;
    localparam int unsigned STEP_COUNT_WIDTH = 16;
    localparam int unsigned RATE_WIDTH       = 32;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_RES,
        STOPPED
    } step_state_t;

    // BASE >> rate_sel, floored at one cycle so a tiny base still ticks.
    function automatic logic [RATE_WIDTH-1:0] rate_period(
        input logic [RATE_WIDTH-1:0] base,
        input logic [2:0]            sel
    );
        logic [RATE_WIDTH-1:0] p;
        p = base >> sel;
        return (p == '0) ? RATE_WIDTH'(1) : p;
    endfunction

endpackage

// File: rtl/step_rate_timer.sv
// -----------------------------------------------------------------------------
// step_rate_timer
//   Free-run step rate generator. Emits a one-cycle tick every
//   (BASE >> rate_sel) cycles while enable is high. BASE is CLK_FREQUENCY_HZ,
//   or 256 when SIMULATE is set so simulations stay short.
//   Ports:
//     clk       system clock, rising edge
//     resetn    asynchronous active-low reset
//     enable    counting enable (controller running flag)
//     rate_sel  rate selector, sampled only when the counter reloads
//     tick      registered one-cycle tick
// -----------------------------------------------------------------------------
module step_rate_timer
    import stackCPU_DEFS::*;
#(
    parameter int unsigned CLK_FREQUENCY_HZ = 8000000,
    parameter int unsigned SIMULATE         = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [2:0] rate_sel,
    output logic       tick
);

    localparam logic [RATE_WIDTH-1:0] BASE =
        (SIMULATE != 0) ? RATE_WIDTH'(256) : RATE_WIDTH'(CLK_FREQUENCY_HZ);

    logic [RATE_WIDTH-1:0] count;
    logic [RATE_WIDTH-1:0] reload_value;
    logic                  enable_q;

    // A count cycle runs reload_value..0, i.e. exactly one period per tick.
    always_comb begin
        reload_value = rate_period(BASE, rate_sel) - RATE_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            enable_q <= 1'b0;
            tick     <= 1'b0;
        end else begin
            enable_q <= enable;
            tick     <= 1'b0;
            if (!enable) begin
                count <= '0;
            end else if (!enable_q) begin
                // running just rose: start a fresh period
                count <= reload_value;
            end else if (count == '0) begin
                tick  <= 1'b1;
                count <= reload_value;
            end else begin
                count <= count - RATE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/step_controller.sv
// -----------------------------------------------------------------------------
// step_controller
//   Single-step / free-run controller for the stackCPU. Issues one-cycle
//   single_step pulses from the step button or, in run mode, from the rate
//   timer; waits for valid_result (bounded by WAIT_TIMEOUT), counts completed
//   steps, stops on a program-counter breakpoint and locks up on halt/error
//   until reset.
//   Ports:
//     clk, resetn        clock (rising edge) / asynchronous active-low reset
//     step_btn, run_btn  debounced button levels (rising edge is the event)
//     rate_sel           run rate, 2^rate_sel steps per base period
//     bp_enable, bp_addr breakpoint enable and program-counter value
//     pc, valid_result,
//     halt, error        stackCPU status
//     single_step        one-cycle step pulse to the stackCPU
//     running            free-run mode active
//     bp_hit             sticky: stopped at the breakpoint
//     step_count         completed steps, wraps at 16 bits
// -----------------------------------------------------------------------------
module step_controller
    import stackCPU_DEFS::*;
#(
    parameter int unsigned CLK_FREQUENCY_HZ = 8000000,
    parameter int unsigned SIMULATE         = 0,
    parameter int unsigned WAIT_TIMEOUT     = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        step_btn,
    input  logic                        run_btn,
    input  logic [2:0]                  rate_sel,
    input  logic                        bp_enable,
    input  logic [PC_WIDTH_DEF-1:0]     bp_addr,
    input  logic [PC_WIDTH_DEF-1:0]     pc,
    input  logic                        valid_result,
    input  logic                        halt,
    input  logic                        error,
    output logic                        single_step,
    output logic                        running,
    output logic                        bp_hit,
    output logic [STEP_COUNT_WIDTH-1:0] step_count
);

    localparam int unsigned      TO_W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(WAIT_TIMEOUT - 1);

    step_state_t                 state;
    logic [TO_W-1:0]             timeout_cnt;
    logic [STEP_COUNT_WIDTH-1:0] count_q;
    logic                        tick;
    logic                        tick_pending;
    logic                        step_q;
    logic                        run_q;
    logic                        step_edge;
    logic                        run_edge;
    logic                        fault;
    logic                        tick_avail;
    logic                        bp_match;
    logic                        timed_out;

    step_rate_timer #(
        .CLK_FREQUENCY_HZ (CLK_FREQUENCY_HZ),
        .SIMULATE         (SIMULATE)
    ) u_rate_timer (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (running),
        .rate_sel (rate_sel),
        .tick     (tick)
    );

    always_comb begin
        step_edge  = step_btn & ~step_q;
        run_edge   = run_btn & ~run_q;
        fault      = halt | error;
        tick_avail = tick | tick_pending;
        bp_match   = bp_enable && (pc == bp_addr);
        timed_out  = (timeout_cnt == TO_LAST);
    end

    assign step_count = count_q;

    // Later assignments in this block deliberately override earlier ones:
    // the run toggle is applied first, then state-specific effects
    // (fault, breakpoint) force running low on top of it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            single_step  <= 1'b0;
            running      <= 1'b0;
            bp_hit       <= 1'b0;
            count_q      <= '0;
            tick_pending <= 1'b0;
            timeout_cnt  <= '0;
            // copies start high so a button held through reset is not an edge
            step_q       <= 1'b1;
            run_q        <= 1'b1;
        end else begin
            step_q      <= step_btn;
            run_q       <= run_btn;
            single_step <= 1'b0;

            if (state != STOPPED && run_edge) begin
                running <= ~running;
                if (!running) begin
                    bp_hit <= 1'b0;
                end
            end

            // one-deep hold of ticks that arrive while a step is in flight
            if (tick && running && state != IDLE) begin
                tick_pending <= 1'b1;
            end
            if (running && run_edge) begin
                tick_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fault) begin
                        state        <= STOPPED;
                        running      <= 1'b0;
                        tick_pending <= 1'b0;
                    end else if (step_edge && !running) begin
                        state       <= PULSE;
                        single_step <= 1'b1;
                        bp_hit      <= 1'b0;
                    end else if (running && tick_avail && !run_edge) begin
                        // a run edge here is pausing, so the tick is dropped
                        state        <= PULSE;
                        single_step  <= 1'b1;
                        tick_pending <= 1'b0;
                    end
                end

                PULSE: begin
                    state       <= WAIT_RES;
                    timeout_cnt <= '0;
                end

                WAIT_RES: begin
                    if (valid_result || (timed_out && !fault)) begin
                        count_q <= count_q + 1'b1;
                    end
                    if (fault) begin
                        state        <= STOPPED;
                        running      <= 1'b0;
                        tick_pending <= 1'b0;
                        timeout_cnt  <= '0;
                    end else if (valid_result) begin
                        state       <= IDLE;
                        timeout_cnt <= '0;
                        if (bp_match) begin
                            bp_hit       <= 1'b1;
                            running      <= 1'b0;
                            tick_pending <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state       <= IDLE;
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end

                STOPPED: begin
                    running      <= 1'b0;
                    tick_pending <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 Parameter CLK_FREQUENCY_HZ, default 8000000, system clock frequency used for run-rate timing.
REQ-002 Parameter SIMULATE, default 0; when 1, the run-rate base period is 256 cycles instead of CLK_FREQUENCY_HZ.
REQ-003 Parameter WAIT_TIMEOUT, default 16, the maximum number of cycles to wait for valid_result after a step pulse.
REQ-004 clk  input  1  system clock (8 MHz domain); all logic is rising-edge.
REQ-005 resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 step_btn  input  1  debounced single-step button level.
REQ-007 run_btn  input  1  debounced run/pause toggle button level.
REQ-008 rate_sel  input  3  run rate: 2^rate_sel steps per base period.
REQ-009 bp_enable  input  1  breakpoint enable.
REQ-010 bp_addr  input  PC_WIDTH_DEF  breakpoint program-counter value.
REQ-011 pc  input  PC_WIDTH_DEF  stackCPU program counter.
REQ-012 valid_result, halt, error  input  1 each  stackCPU status.
REQ-013 single_step  output  1  one-cycle step pulse to stackCPU.
REQ-014 running  output  1  free-run mode active.
REQ-015 bp_hit  output  1  sticky flag: stopped at the breakpoint.
REQ-016 step_count  output  16  number of completed steps.

Function
REQ-017 Rising edges of step_btn and run_btn shall be detected against a registered copy of each level; that copy resets to 1, so a button held through reset produces no edge.
REQ-018 FSM states (step_state_t): IDLE, PULSE, WAIT_RES, STOPPED.
REQ-019 IDLE: halt or error goes to STOPPED; otherwise a step edge with running=0 goes to PULSE; otherwise a pending tick with running=1 goes to PULSE.
REQ-020 PULSE: single_step=1 for exactly this one cycle, then go to WAIT_RES; single_step shall be 0 in every other state.
REQ-021 WAIT_RES, when valid_result=1: step_count+1; if bp_enable and pc==bp_addr in the same cycle, set bp_hit and clear running; go to IDLE.
REQ-022 WAIT_RES, when WAIT_TIMEOUT cycles pass without valid_result: step_count+1, no breakpoint check, go to IDLE.
REQ-023 WAIT_RES, when halt or error=1: go to STOPPED; this takes priority over valid_result in the same cycle, but the count is still incremented if valid_result=1.
REQ-024 STOPPED: running=0, no pulses are issued, and button edges are ignored; the only exit is reset.
REQ-025 A run edge in IDLE, PULSE or WAIT_RES toggles running; a run edge that sets running also clears bp_hit.
REQ-026 A step edge while running=1, or while in PULSE or WAIT_RES, is ignored and not queued; a step edge that is accepted clears bp_hit.
REQ-027 Rate timer: period = BASE >> rate_sel cycles, where BASE = CLK_FREQUENCY_HZ, or 256 when SIMULATE=1.
REQ-028 The rate timer is reloaded when running rises, counts down only while running=1, and generates a tick on reaching 0, then reloads.
REQ-029 A tick outside IDLE is held pending (one-deep); the pending flag is cleared when consumed or when running falls.
REQ-030 A run edge that clears running in the same cycle as a tick in IDLE wins: no pulse is issued.
REQ-031 A rate_sel change takes effect at the next reload.
REQ-032 step_count wraps from 0xFFFF to 0x0000.

Reset
REQ-033 While resetn=0: state=IDLE, single_step=0, running=0, bp_hit=0, step_count=0, tick pending=0, timeout counter=0, rate timer=0.
REQ-034 Reset asserted mid-operation (PULSE or WAIT_RES) aborts the step immediately with no count increment.

Structure
REQ-035 step_state_t and STEP_COUNT_WIDTH=16 shall be defined in stackCPU_DEFS; PC_WIDTH_DEF shall be taken from that package.
REQ-036 The rate timer shall be one sub-module, step_rate_timer (inputs: clk, resetn, enable, rate_sel; output: tick).

Verification
REQ-037 Reset, then step_btn 0->1 with valid_result 3 cycles after the pulse -> exactly one single_step pulse, step_count=1, state=IDLE.
REQ-038 SIMULATE=1, rate_sel=2, run edge -> pulses every 64 cycles while valid_result arrives within the window; a second run edge -> pulses stop and running=0.
REQ-039 Running with bp_enable=1, bp_addr=8'h05, pc sequence 3,4,5 -> bp_hit=1 and running=0 after the third result; step_count=3.
REQ-040 halt asserted in WAIT_RES -> STOPPED; subsequent step and run edges produce no pulse until resetn pulses low.
REQ-041 No valid_result after a pulse -> return to IDLE after 16 cycles with step_count incremented; a step edge during the wait is ignored.
REQ-042 step_count preloaded to 0xFFFF by stepping, one more step -> 0x0000; resetn low mid-WAIT_RES -> all outputs reset, no increment.
